wrr_client_requester: RTL and testbench

- Client-side counterpart to the weighted round-robin lock arbiter: turns per-client burst commands into the arbiter's req/lock inputs and consumes its one-hot grant.
- Each client queues burst commands in a small FIFO and raises req for each burst. It holds lock for the duration of a multi-beat burst, counts granted beats, and reports beat/done events.
- Starvation and protocol-error monitors cover the arbiter side.

---
 rtl/wrr_client_requester.sv | 188 ++++++++++++++++++
 tb/tb_wrr_client_requester.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wrr_client_requester.sv
// Client-side requester for the weighted round-robin lock arbiter.
// Each client buffers burst commands in a small FIFO, requests the arbiter
// for every burst, holds lock until the final beat and reports beat/done
// events. Starvation and grant-protocol monitors watch the arbiter side.
module wrr_client_requester #(
    parameter int NUM_CLIENTS  = 4,
    parameter int LEN_WIDTH    = 4,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 64
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_CLIENTS-1:0]           i_cmd_valid,
    output logic [NUM_CLIENTS-1:0]           o_cmd_ready,
    input  logic [NUM_CLIENTS*LEN_WIDTH-1:0] i_cmd_len,
    output logic [NUM_CLIENTS-1:0]           o_req,
    output logic [NUM_CLIENTS-1:0]           o_lock,
    input  logic [NUM_CLIENTS-1:0]           i_gnt,
    output logic [NUM_CLIENTS-1:0]           o_beat,
    output logic [NUM_CLIENTS-1:0]           o_done,
    output logic [NUM_CLIENTS-1:0]           o_starve,
    output logic                             o_gnt_err
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int REM_W = LEN_WIDTH + 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_BURST = 2'd2
    } state_t;

    // True when more than one bit of the vector is set.
    function automatic logic is_multi_hot(input logic [NUM_CLIENTS-1:0] v);
        logic [NUM_CLIENTS-1:0] low_cleared;
        low_cleared = v & (v - {{(NUM_CLIENTS-1){1'b0}}, 1'b1});
        return (low_cleared != {NUM_CLIENTS{1'b0}});
    endfunction

    logic gnt_bad_s;
    logic gnt_err_r;

    for (genvar g = 0; g < NUM_CLIENTS; g++) begin : g_client
        state_t               state_r;
        state_t               state_nxt_s;
        logic [LEN_WIDTH-1:0] mem_r [FIFO_DEPTH];
        logic [PTR_W-1:0]     wr_ptr_r;
        logic [PTR_W-1:0]     rd_ptr_r;
        logic [CNT_W-1:0]     count_r;
        logic [REM_W-1:0]     rem_r;
        logic [REM_W-1:0]     rem_nxt_s;
        logic [STV_W-1:0]     starve_r;
        logic [STV_W-1:0]     starve_nxt_s;
        logic [REM_W-1:0]     head_beats_s;
        logic [LEN_WIDTH-1:0] cmd_len_s;
        logic                 full_s;
        logic                 nonempty_s;
        logic                 push_s;
        logic                 pop_s;
        logic                 beat_s;
        logic                 last_s;

        assign cmd_len_s    = i_cmd_len[g*LEN_WIDTH +: LEN_WIDTH];
        assign full_s       = (count_r == CNT_W'(FIFO_DEPTH));
        // Occupancy before this cycle, so a fresh push is poppable next cycle.
        assign nonempty_s   = (count_r != {CNT_W{1'b0}});
        assign push_s       = i_cmd_valid[g] & ~full_s;
        assign head_beats_s = {1'b0, mem_r[rd_ptr_r]} + REM_W'(1);
        assign beat_s       = i_gnt[g] & o_req[g];
        assign last_s       = beat_s & (rem_r == REM_W'(1));

        assign o_cmd_ready[g] = ~full_s;
        assign o_req[g]       = (state_r != ST_IDLE);
        assign o_lock[g]      = (state_r != ST_IDLE) & (rem_r > REM_W'(1));
        assign o_beat[g]      = beat_s;
        assign o_done[g]      = last_s;
        assign o_starve[g]    = (starve_r == STV_W'(STARVE_LIMIT));

        // Next-state, remaining-beat and FIFO-pop decode for this client
        always_comb begin
            state_nxt_s = state_r;
            rem_nxt_s   = rem_r;
            pop_s       = 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (nonempty_s) begin
                        pop_s       = 1'b1;
                        rem_nxt_s   = head_beats_s;
                        state_nxt_s = ST_WAIT;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_WAIT, ST_BURST: begin
                    if (last_s) begin
                        // Chain straight into the next burst with no idle gap.
                        if (nonempty_s) begin
                            pop_s       = 1'b1;
                            rem_nxt_s   = head_beats_s;
                            state_nxt_s = ST_WAIT;
                        end else begin
                            rem_nxt_s   = {REM_W{1'b0}};
                            state_nxt_s = ST_IDLE;
                        end
                    end else if (beat_s) begin
                        rem_nxt_s   = rem_r - REM_W'(1);
                        state_nxt_s = ST_BURST;
                    end else begin
                        state_nxt_s = state_r;
                    end
                end
                default: begin
                    rem_nxt_s   = {REM_W{1'b0}};
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end

        // Starvation counter: counts waiting cycles, saturates, clears otherwise
        always_comb begin
            starve_nxt_s = starve_r;
            if (beat_s || (state_r != ST_WAIT)) begin
                starve_nxt_s = {STV_W{1'b0}};
            end else if (starve_r == STV_W'(STARVE_LIMIT)) begin
                starve_nxt_s = starve_r;
            end else begin
                starve_nxt_s = starve_r + STV_W'(1);
            end
        end

        // FSM state, remaining-beat and starvation registers
        always_ff @(posedge clk) begin
            if (rst) begin
                state_r  <= ST_IDLE;
                rem_r    <= {REM_W{1'b0}};
                starve_r <= {STV_W{1'b0}};
            end else begin
                state_r  <= state_nxt_s;
                rem_r    <= rem_nxt_s;
                starve_r <= starve_nxt_s;
            end
        end

        // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH
        always_ff @(posedge clk) begin
            if (rst) begin
                wr_ptr_r <= {PTR_W{1'b0}};
                rd_ptr_r <= {PTR_W{1'b0}};
                count_r  <= {CNT_W{1'b0}};
            end else begin
                if (push_s) begin
                    wr_ptr_r <= wr_ptr_r + PTR_W'(1);
                end
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + PTR_W'(1);
                end
                case ({push_s, pop_s})
                    2'b10:   count_r <= count_r + CNT_W'(1);
                    2'b01:   count_r <= count_r - CNT_W'(1);
                    default: count_r <= count_r;
                endcase
            end
        end

        // FIFO storage; contents are don't-care while the entry is unoccupied
        always_ff @(posedge clk) begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= cmd_len_s;
            end
        end
    end

    assign gnt_bad_s = is_multi_hot(i_gnt) | (|(i_gnt & ~o_req));
    assign o_gnt_err = gnt_err_r;

    // Register grant-protocol violations seen this cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_err_r <= 1'b0;
        end else begin
            gnt_err_r <= gnt_bad_s;
        end
    end

endmodule

// File: tb/tb_wrr_client_requester.sv
// Directed bench for wrr_client_requester with a per-client burst scoreboard.
module tb_wrr_client_requester;

    localparam int N  = 4;
    localparam int LW = 4;
    localparam int FD = 4;
    localparam int SL = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    i_cmd_valid;
    logic [N-1:0]    o_cmd_ready;
    logic [N*LW-1:0] i_cmd_len;
    logic [N-1:0]    o_req;
    logic [N-1:0]    o_lock;
    logic [N-1:0]    i_gnt;
    logic [N-1:0]    o_beat;
    logic [N-1:0]    o_done;
    logic [N-1:0]    o_starve;
    logic            o_gnt_err;

    int checks     = 0;
    int failures   = 0;
    int exp_q [N][$];
    int beats_seen [N];
    int dones_total = 0;

    always #5 clk = ~clk;

    wrr_client_requester #(
        .NUM_CLIENTS (N),
        .LEN_WIDTH   (LW),
        .FIFO_DEPTH  (FD),
        .STARVE_LIMIT(SL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_cmd_valid(i_cmd_valid),
        .o_cmd_ready(o_cmd_ready),
        .i_cmd_len  (i_cmd_len),
        .o_req      (o_req),
        .o_lock     (o_lock),
        .i_gnt      (i_gnt),
        .o_beat     (o_beat),
        .o_done     (o_done),
        .o_starve   (o_starve),
        .o_gnt_err  (o_gnt_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_cmd(input int c, input logic [LW-1:0] len);
        i_cmd_valid[c]        = 1'b1;
        i_cmd_len[c*LW +: LW] = len;
    endtask

    // Scoreboard: accepted commands push their beat count, o_done pops it.
    task automatic sb_sample();
        int e;
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                exp_q[i].delete();
                beats_seen[i] = 0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (i_cmd_valid[i] && o_cmd_ready[i]) begin
                    exp_q[i].push_back(int'(i_cmd_len[i*LW +: LW]) + 1);
                end
                if (o_beat[i]) beats_seen[i]++;
                if (o_done[i]) begin
                    dones_total++;
                    if (exp_q[i].size() == 0) begin
                        check($sformatf("sb_unexpected_done_c%0d", i), {31'd0, o_done[i]}, 32'd0);
                    end else begin
                        e = exp_q[i].pop_front();
                        check($sformatf("sb_burst_beats_c%0d", i), beats_seen[i], e);
                    end
                    beats_seen[i] = 0;
                end
            end
        end
    endtask

    // Sample the scoreboard mid-cycle, then land 1 time unit after the next edge.
    task automatic next_cycle();
        @(negedge clk);
        sb_sample();
        @(posedge clk);
        #1;
    endtask

    logic [LW-1:0] t3_lens [10];
    int acc;
    int t3_beats;

    initial begin
        rst         = 1'b1;
        i_cmd_valid = '0;
        i_cmd_len   = '0;
        i_gnt       = '0;
        for (int i = 0; i < N; i++) beats_seen[i] = 0;
        t3_lens = '{4'd1, 4'd3, 4'd0, 4'd2, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9};

        // Reset state
        next_cycle();
        next_cycle();
        #1;
        check("rst_cmd_ready", o_cmd_ready, 32'hf);
        check("rst_req",       o_req,       32'h0);
        check("rst_lock",      o_lock,      32'h0);
        check("rst_beat",      o_beat,      32'h0);
        check("rst_done",      o_done,      32'h0);
        check("rst_starve",    o_starve,    32'h0);
        check("rst_gnt_err",   o_gnt_err,   32'h0);
        rst = 1'b0;
        next_cycle();

        // Single burst: client 1, len=2 (3 beats)
        set_cmd(1, 4'd2);
        #1;
        check("t1_ready", o_cmd_ready[1], 32'h1);
        next_cycle();
        i_cmd_valid = '0;
        #1;
        check("t1_req_pop_cycle", o_req[1], 32'h0);
        next_cycle();
        #1;
        check("t1_req_wait", o_req, 32'h2);
        i_gnt = 4'b0010;
        for (int b = 0; b < 3; b++) begin
            #1;
            check($sformatf("t1_beat_%0d", b), o_beat, 32'h2);
            check($sformatf("t1_lock_%0d", b), o_lock[1], (b < 2) ? 32'h1 : 32'h0);
            check($sformatf("t1_done_%0d", b), o_done, (b == 2) ? 32'h2 : 32'h0);
            next_cycle();
        end
        i_gnt = '0;
        #1;
        check("t1_req_after", o_req, 32'h0);
        check("t1_gnt_err", o_gnt_err, 32'h0);

        // Back-to-back: client 0, len=0 then len=1, grant held
        set_cmd(0, 4'd0);
        next_cycle();
        set_cmd(0, 4'd1);
        #1;
        check("t2_req_idle", o_req[0], 32'h0);
        next_cycle();
        i_cmd_valid = '0;
        i_gnt       = 4'b0001;
        for (int b = 0; b < 3; b++) begin
            #1;
            check($sformatf("t2_req_%0d", b),  o_req[0],  32'h1);
            check($sformatf("t2_beat_%0d", b), o_beat,    32'h1);
            check($sformatf("t2_lock_%0d", b), o_lock[0], (b == 1) ? 32'h1 : 32'h0);
            check($sformatf("t2_done_%0d", b), o_done[0], (b == 1) ? 32'h0 : 32'h1);
            next_cycle();
        end
        i_gnt = '0;
        #1;
        check("t2_req_after", o_req[0], 32'h0);

        // FIFO full and wrap: client 2 fills with no grants, then drains
        acc = 0;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (!o_cmd_ready[2]) break;
            set_cmd(2, t3_lens[acc]);
            acc++;
            next_cycle();
        end
        i_cmd_valid = '0;
        #1;
        check("t3_accepted", acc, FD + 1);
        check("t3_ready_full", o_cmd_ready[2], 32'h0);
        t3_beats = 0;
        for (int k = 0; k < 20; k++) begin
            i_gnt = {1'b0, o_req[2], 2'b00};
            #1;
            if (o_beat[2]) t3_beats++;
            next_cycle();
        end
        i_gnt = '0;
        #1;
        check("t3_beats", t3_beats, 32'd15);
        check("t3_ready_back", o_cmd_ready[2], 32'h1);
        check("t3_req_idle", o_req[2], 32'h0);

        // Starvation: client 3 waits SL cycles without grant
        set_cmd(3, 4'd1);
        next_cycle();
        i_cmd_valid = '0;
        next_cycle();
        #1;
        check("t4_req", o_req[3], 32'h1);
        check("t4_starve_start", o_starve[3], 32'h0);
        for (int k = 0; k < SL - 1; k++) next_cycle();
        #1;
        check("t4_starve_before", o_starve[3], 32'h0);
        next_cycle();
        #1;
        check("t4_starve_at_limit", o_starve[3], 32'h1);
        for (int k = 0; k < 5; k++) next_cycle();
        #1;
        check("t4_starve_saturated", o_starve[3], 32'h1);
        i_gnt = 4'b1000;
        #1;
        check("t4_starve_grant_cycle", o_starve[3], 32'h1);
        check("t4_beat", o_beat, 32'h8);
        next_cycle();
        #1;
        check("t4_starve_cleared", o_starve[3], 32'h0);
        check("t4_done", o_done, 32'h8);
        next_cycle();
        i_gnt = '0;

        // Grant error: grant on a non-requesting client
        set_cmd(0, 4'd1);
        next_cycle();
        i_cmd_valid = '0;
        next_cycle();
        i_gnt = 4'b0011;
        #1;
        check("t5_beat", o_beat, 32'h1);
        check("t5_done", o_done, 32'h0);
        next_cycle();
        i_gnt = '0;
        #1;
        check("t5_gnt_err", o_gnt_err, 32'h1);
        check("t5_req1_unchanged", o_req[1], 32'h0);
        check("t5_req0", o_req[0], 32'h1);
        check("t5_lock0", o_lock[0], 32'h0);
        next_cycle();
        #1;
        check("t5_gnt_err_clear", o_gnt_err, 32'h0);
        i_gnt = 4'b0001;
        #1;
        check("t5_done_last", o_done, 32'h1);
        next_cycle();
        i_gnt = '0;

        // Grant error: multi-hot grant with both clients requesting
        set_cmd(0, 4'd0);
        set_cmd(1, 4'd0);
        next_cycle();
        i_cmd_valid = '0;
        next_cycle();
        i_gnt = 4'b0011;
        #1;
        check("t5m_beat", o_beat, 32'h3);
        check("t5m_done", o_done, 32'h3);
        next_cycle();
        i_gnt = '0;
        #1;
        check("t5m_gnt_err", o_gnt_err, 32'h1);
        check("t5m_req", o_req, 32'h0);

        // Reset mid-burst with a queued command behind it
        set_cmd(0, 4'd3);
        next_cycle();
        set_cmd(0, 4'd0);
        next_cycle();
        i_cmd_valid = '0;
        i_gnt       = 4'b0001;
        #1;
        check("t6_beat", o_beat, 32'h1);
        next_cycle();
        #1;
        check("t6_lock_burst", o_lock[0], 32'h1);
        rst = 1'b1;
        next_cycle();
        i_gnt = '0;
        #1;
        check("t6_req", o_req, 32'h0);
        check("t6_lock", o_lock, 32'h0);
        check("t6_ready", o_cmd_ready, 32'hf);
        check("t6_done", o_done, 32'h0);
        rst = 1'b0;
        next_cycle();
        next_cycle();
        #1;
        check("t6_req_discarded", o_req, 32'h0);
        check("t6_done_none", o_done, 32'h0);
        next_cycle();

        // Scoreboard closure
        for (int i = 0; i < N; i++) begin
            check($sformatf("sb_leftover_c%0d", i), exp_q[i].size(), 32'd0);
        end
        check("sb_done_total", dones_total, 32'd12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
